display_mode_ctrl: RTL and testbench
====================================

// Module: display_mode_ctrl
// PURPOSE
//  Sequences the shared 4-digit seven-segment display between time (HH:MM) and date (DD.MM) views.
//  Runs the button-driven set mode: selects the field being edited, blinks it and emits
//  one-cycle increment pulses to the time/date counters.
//  Sits between the counters and the seg7 multiplexer; it drives that block's digit inputs and a blank mask.
// PARAMETERS
//  TICK_DIV    100_000_000  clocks per 1 s tick
//  BLINK_DIV    25_000_000  clocks per blink-phase toggle (2 Hz blink)
//  TIME_SEC     10          seconds time view is held before auto-rotate to date
//  DATE_SEC     3           seconds date view is held before returning to time
//  IDLE_SEC     15          seconds without a button in set mode before auto-exit
// PORTS
//  clk_100MHz  in   1  system clock
//  reset       in   1  asynchronous, active-high reset
//  btn_mode    in   1  debounced 1-cycle pulse: enter/abort set mode
//  btn_next    in   1  debounced 1-cycle pulse: advance to next set field
//  btn_inc     in   1  debounced 1-cycle pulse: increment current field
//  auto_rot    in   1  1 = enable time/date auto-rotation
//  hrs_tens    in   3 ; hrs_ones in 4 ; mins_tens in 3 ; mins_ones in 4   BCD time
//  day_tens    in   2 ; day_ones in 4 ; mon_tens  in 1 ; mon_ones  in 4   BCD date
//  dig3..dig0  out  4  BCD to display, dig3 = leftmost; zero-extended from source width
//  blank       out  4  1 = blank digit n (bit3 = dig3)
//  inc_hrs, inc_mins, inc_day, inc_mon  out 1  1-cycle increment pulses
//  mode        out  3  current state code
// BEHAVIOUR
//  States: SHOW_TIME, SHOW_DATE, SET_HRS, SET_MINS, SET_DAY, SET_MON.
//  Reset: SHOW_TIME; dig* = 0, blank = 4'b0000, inc_* = 0, all counters and blink phase = 0.
//  Button priority when pulses coincide: btn_mode > btn_next > btn_inc; only the winner acts.
//  Transitions:
//   - SHOW_TIME -> SHOW_DATE after TIME_SEC ticks when auto_rot = 1.
//   - SHOW_DATE -> SHOW_TIME after DATE_SEC ticks (always).
//   - SHOW_* + btn_mode -> SET_HRS.
//   - SET_* + btn_mode -> SHOW_TIME (abort).
//   - btn_next: SET_HRS -> SET_MINS -> SET_DAY -> SET_MON -> SHOW_TIME.
//   - SET_* with no button for IDLE_SEC ticks -> SHOW_TIME.
//   - auto_rot 1->0 while in SHOW_DATE: still returns after DATE_SEC.
//  View counter: clears on every state change and on every button pulse; counts 1 s ticks.
//   Transition fires on the tick that makes the count equal the limit.
//  Tick prescaler: free-running, never cleared except by reset. First timeout may be up to 1 tick early.
//  btn_inc in SET_x: inc_x = 1 on the next cycle for exactly one cycle. Other inc_* stay 0.
//   btn_inc in SHOW_* is ignored.
//  Blink:
//   - Phase toggles every BLINK_DIV clocks.
//   - Forced to 0 (visible) and its counter cleared on entry to any SET state and on each btn_inc.
//   - In SET state with phase = 1, the edited field's two digits are blanked:
//     HRS/DAY -> blank = 4'b1100; MINS/MON -> blank = 4'b0011.
//   - In SHOW states, blank = 0.
//  Display source: SHOW_TIME/SET_HRS/SET_MINS show hrs/mins; SHOW_DATE/SET_DAY/SET_MON show day/mon.
//  Latency: dig*, blank and mode are registered; 1 cycle from input or state change.
//  Counters saturate at their limit; no wrap.
//  Reset mid-operation: any state returns to reset values; pending inc pulses are dropped.
// STRUCTURE
//  calendar_pkg: state enum encoding, field codes, blank-mask constants.
//  Sub-module tick_gen #(DIV): modulo-DIV counter giving a 1-cycle pulse. Instanced twice (1 s tick, blink).
//  FSM, view counter, output mux and inc pulse regs stay in this module.
// TESTING  (sim params: TICK_DIV=10, BLINK_DIV=4, TIME_SEC=3, DATE_SEC=2, IDLE_SEC=5)
//  1. Reset mid-SET_MINS -> mode = SHOW_TIME, dig/blank/inc all 0 while reset high.
//  2. auto_rot=1, time 12:34, date 05.11 -> dig = 1,2,3,4 for 3 ticks; then 0,5,1,1 for 2 ticks;
//     then back to 1,2,3,4.
//  3. btn_mode, then btn_inc x3 in SET_HRS -> three single-cycle inc_hrs pulses, each 1 cycle
//     after the button; blank toggles 0000/1100 every 4 clocks, restarting visible on each inc.
//  4. btn_next x4 from SET_HRS -> SET_MINS (blank 0011), SET_DAY (date shown), SET_MON, SHOW_TIME.
//  5. Same-cycle btn_mode + btn_inc in SET_DAY -> SHOW_TIME, no inc_day pulse.
//  6. SET_MINS idle 5 ticks -> SHOW_TIME. A btn_next at tick 4 restarts the count (now SET_DAY).

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared types for the clock/calendar display slice: state encoding, edit fields
// and the digit blank masks used while a field is being set.
package calendar_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME = 3'd0,
    SHOW_DATE = 3'd1,
    SET_HRS   = 3'd2,
    SET_MINS  = 3'd3,
    SET_DAY   = 3'd4,
    SET_MON   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    FLD_HRS  = 2'd0,
    FLD_MINS = 2'd1,
    FLD_DAY  = 2'd2,
    FLD_MON  = 2'd3
  } field_t;

  localparam logic [3:0] BLANK_NONE  = 4'b0000;
  localparam logic [3:0] BLANK_LEFT  = 4'b1100;
  localparam logic [3:0] BLANK_RIGHT = 4'b0011;

  function automatic logic is_set(input state_t s);
    return (s == SET_HRS) || (s == SET_MINS) || (s == SET_DAY) || (s == SET_MON);
  endfunction

  function automatic field_t field_of(input state_t s);
    case (s)
      SET_MINS: return FLD_MINS;
      SET_DAY:  return FLD_DAY;
      SET_MON:  return FLD_MON;
      default:  return FLD_HRS;
    endcase
  endfunction

  // Hours and day occupy the left digit pair, minutes and month the right.
  function automatic logic [3:0] field_mask(input field_t f);
    return ((f == FLD_HRS) || (f == FLD_DAY)) ? BLANK_LEFT : BLANK_RIGHT;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter producing a one-cycle tick on its last count; clr restarts the period.
module tick_gen #(
  parameter int unsigned DIV = 100_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (clr || tick)   cnt <= '0;
    else                    cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/display_mode_ctrl.sv
// Time/date view sequencer and button-driven set mode for the 4-digit seven-segment display.
module display_mode_ctrl
  import calendar_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned TIME_SEC  = 10,
  parameter int unsigned DATE_SEC  = 3,
  parameter int unsigned IDLE_SEC  = 15
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       auto_rot,
  input  logic [2:0] hrs_tens,
  input  logic [3:0] hrs_ones,
  input  logic [2:0] mins_tens,
  input  logic [3:0] mins_ones,
  input  logic [1:0] day_tens,
  input  logic [3:0] day_ones,
  input  logic       mon_tens,
  input  logic [3:0] mon_ones,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] blank,
  output logic       inc_hrs,
  output logic       inc_mins,
  output logic       inc_day,
  output logic       inc_mon,
  output logic [2:0] mode
);

  localparam int unsigned MAX_SEC =
    (TIME_SEC > DATE_SEC) ? ((TIME_SEC > IDLE_SEC) ? TIME_SEC : IDLE_SEC)
                          : ((DATE_SEC > IDLE_SEC) ? DATE_SEC : IDLE_SEC);
  localparam int unsigned VW = $clog2(MAX_SEC + 1);

  state_t          state, state_nxt;
  logic [VW-1:0]   view_cnt;
  logic            sec_tick, blink_tick, phase;
  logic            view_clr, blink_clr, timeout;
  logic [3:0]      inc_nxt, inc_q;
  logic            show_date_src;

  tick_gen #(.DIV(TICK_DIV))  u_sec_tick   (.clk_100MHz(clk_100MHz), .reset(reset), .clr(1'b0),
                                            .tick(sec_tick));
  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (.clk_100MHz(clk_100MHz), .reset(reset), .clr(blink_clr),
                                            .tick(blink_tick));

  // ">=" rather than "==" so a limit already passed (e.g. auto_rot enabled late) still fires.
  always_comb begin
    timeout = 1'b0;
    if (sec_tick) begin
      case (state)
        SHOW_TIME: timeout = auto_rot && (view_cnt >= VW'(TIME_SEC - 1));
        SHOW_DATE: timeout = (view_cnt >= VW'(DATE_SEC - 1));
        default:   timeout = (view_cnt >= VW'(IDLE_SEC - 1));
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    inc_nxt   = '0;
    blink_clr = 1'b0;
    view_clr  = btn_mode | btn_next | btn_inc;
    if (btn_mode) begin
      state_nxt = is_set(state) ? SHOW_TIME : SET_HRS;
    end else if (btn_next) begin
      case (state)
        SET_HRS:  state_nxt = SET_MINS;
        SET_MINS: state_nxt = SET_DAY;
        SET_DAY:  state_nxt = SET_MON;
        SET_MON:  state_nxt = SHOW_TIME;
        default:  state_nxt = state;
      endcase
    end else if (btn_inc) begin
      if (is_set(state)) begin
        blink_clr = 1'b1;
        inc_nxt[3 - int'(field_of(state))] = 1'b1;
      end
    end else if (timeout) begin
      state_nxt = (state == SHOW_TIME) ? SHOW_DATE : SHOW_TIME;
    end
    if (state_nxt != state) begin
      view_clr = 1'b1;
      if (is_set(state_nxt)) blink_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state    <= SHOW_TIME;
      view_cnt <= '0;
      phase    <= 1'b0;
      inc_q    <= '0;
    end else begin
      state <= state_nxt;
      inc_q <= inc_nxt;
      if (view_clr)                            view_cnt <= '0;
      else if (sec_tick && view_cnt != VW'(MAX_SEC)) view_cnt <= view_cnt + VW'(1);
      if (blink_clr)       phase <= 1'b0;
      else if (blink_tick) phase <= ~phase;
    end
  end

  assign {inc_hrs, inc_mins, inc_day, inc_mon} = inc_q;
  assign show_date_src = (state == SHOW_DATE) || (state == SET_DAY) || (state == SET_MON);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      dig3  <= '0;
      dig2  <= '0;
      dig1  <= '0;
      dig0  <= '0;
      blank <= BLANK_NONE;
      mode  <= SHOW_TIME;
    end else begin
      dig3  <= show_date_src ? {2'b00, day_tens} : {1'b0, hrs_tens};
      dig2  <= show_date_src ? day_ones          : hrs_ones;
      dig1  <= show_date_src ? {3'b000, mon_tens} : {1'b0, mins_tens};
      dig0  <= show_date_src ? mon_ones          : mins_ones;
      blank <= (is_set(state) && phase) ? field_mask(field_of(state)) : BLANK_NONE;
      mode  <= state;
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with shortened tick/blink periods.
module tb_display_mode_ctrl;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, auto_rot = 1'b1;
  logic [2:0] hrs_tens = 3'd1, mins_tens = 3'd3;
  logic [3:0] hrs_ones = 4'd2, mins_ones = 4'd4;
  logic [1:0] day_tens = 2'd0;
  logic [3:0] day_ones = 4'd5, mon_ones = 4'd1;
  logic       mon_tens = 1'b1;
  logic [3:0] dig3, dig2, dig1, dig0, blank;
  logic       inc_hrs, inc_mins, inc_day, inc_mon;
  logic [2:0] mode;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] TIME_V = 16'h1234;
  localparam logic [15:0] DATE_V = 16'h0511;

  display_mode_ctrl #(.TICK_DIV(10), .BLINK_DIV(4), .TIME_SEC(3), .DATE_SEC(2), .IDLE_SEC(5)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_mode(btn_mode), .btn_next(btn_next),
    .btn_inc(btn_inc), .auto_rot(auto_rot), .hrs_tens(hrs_tens), .hrs_ones(hrs_ones),
    .mins_tens(mins_tens), .mins_ones(mins_ones), .day_tens(day_tens), .day_ones(day_ones),
    .mon_tens(mon_tens), .mon_ones(mon_ones), .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .blank(blank), .inc_hrs(inc_hrs), .inc_mins(inc_mins), .inc_day(inc_day), .inc_mon(inc_mon),
    .mode(mode)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  // Leaves time 1ns after the last reset-high edge; the next posedge is cycle 1.
  task automatic apply_reset();
    reset = 1'b1; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
  endtask

  task automatic press(input logic m, input logic n, input logic i);
    btn_mode = m; btn_next = n; btn_inc = i;
    cyc(1);
    btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    press(1, 0, 0);
    press(0, 1, 0);
    cyc(1);
    checks++; if (mode !== 3'd3) begin errors++; $display("FAIL pre_reset_mode got=%0d want=3", mode); end
    checks++; if ({dig3, dig2, dig1, dig0} !== TIME_V) begin errors++; $display("FAIL pre_reset_dig got=%h want=%h", {dig3, dig2, dig1, dig0}, TIME_V); end
    reset = 1'b1;
    #2;
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode got=%0d want=0", mode); end
    checks++; if ({dig3, dig2, dig1, dig0} !== 16'h0000) begin errors++; $display("FAIL reset_dig got=%h want=0000", {dig3, dig2, dig1, dig0}); end
    btn_inc = 1'b1;
    cyc(2);
    btn_inc = 1'b0;
    checks++; if ({blank, inc_hrs, inc_mins, inc_day, inc_mon} !== 8'h00) begin errors++; $display("FAIL reset_blank_inc got=%b want=00000000", {blank, inc_hrs, inc_mins, inc_day, inc_mon}); end
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_hold_mode got=%0d want=0", mode); end
  endtask

  task automatic test_rotation();
    apply_reset();
    cyc(1);
    checks++; if ({dig3, dig2, dig1, dig0} !== TIME_V) begin errors++; $display("FAIL rot_time_start got=%h want=%h", {dig3, dig2, dig1, dig0}, TIME_V); end
    cyc(29);
    checks++; if ({dig3, dig2, dig1, dig0} !== TIME_V) begin errors++; $display("FAIL rot_time_end got=%h want=%h", {dig3, dig2, dig1, dig0}, TIME_V); end
    cyc(1);
    checks++; if ({dig3, dig2, dig1, dig0} !== DATE_V) begin errors++; $display("FAIL rot_date_start got=%h want=%h", {dig3, dig2, dig1, dig0}, DATE_V); end
    checks++; if (mode !== 3'd1) begin errors++; $display("FAIL rot_date_mode got=%0d want=1", mode); end
    auto_rot = 1'b0;
    cyc(19);
    checks++; if ({dig3, dig2, dig1, dig0} !== DATE_V) begin errors++; $display("FAIL rot_date_end got=%h want=%h", {dig3, dig2, dig1, dig0}, DATE_V); end
    cyc(1);
    checks++; if ({dig3, dig2, dig1, dig0} !== TIME_V) begin errors++; $display("FAIL rot_back_time got=%h want=%h", {dig3, dig2, dig1, dig0}, TIME_V); end
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL rot_back_mode got=%0d want=0", mode); end
    auto_rot = 1'b1;
  endtask

  task automatic test_inc_blink();
    apply_reset();
    press(1, 0, 0);
    checks++; if (inc_hrs !== 1'b0) begin errors++; $display("FAIL inc_none_on_mode got=%b want=0", inc_hrs); end
    cyc(4);
    checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL blink_c5 got=%b want=0000", blank); end
    cyc(1);
    checks++; if (blank !== 4'b1100) begin errors++; $display("FAIL blink_c6 got=%b want=1100", blank); end
    checks++; if (mode !== 3'd2) begin errors++; $display("FAIL set_hrs_mode got=%0d want=2", mode); end
    cyc(3);
    checks++; if (blank !== 4'b1100) begin errors++; $display("FAIL blink_c9 got=%b want=1100", blank); end
    cyc(1);
    checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL blink_c10 got=%b want=0000", blank); end
    press(0, 0, 1);
    checks++; if ({inc_hrs, inc_mins, inc_day, inc_mon} !== 4'b1000) begin errors++; $display("FAIL inc1_pulse got=%b want=1000", {inc_hrs, inc_mins, inc_day, inc_mon}); end
    cyc(1);
    checks++; if (inc_hrs !== 1'b0) begin errors++; $display("FAIL inc1_end got=%b want=0", inc_hrs); end
    cyc(3);
    checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL blink_c15 got=%b want=0000", blank); end
    cyc(1);
    checks++; if (blank !== 4'b1100) begin errors++; $display("FAIL blink_c16 got=%b want=1100", blank); end
    press(0, 0, 1);
    checks++; if (inc_hrs !== 1'b1) begin errors++; $display("FAIL inc2_pulse got=%b want=1", inc_hrs); end
    cyc(1);
    checks++; if ({blank, inc_hrs} !== 5'b00000) begin errors++; $display("FAIL inc2_restart got=%b want=00000", {blank, inc_hrs}); end
    press(0, 0, 1);
    checks++; if (inc_hrs !== 1'b1) begin errors++; $display("FAIL inc3_pulse got=%b want=1", inc_hrs); end
    cyc(1);
    checks++; if (inc_hrs !== 1'b0) begin errors++; $display("FAIL inc3_end got=%b want=0", inc_hrs); end
    cyc(3);
    checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL blink_c23 got=%b want=0000", blank); end
    cyc(1);
    checks++; if (blank !== 4'b1100) begin errors++; $display("FAIL blink_c24 got=%b want=1100", blank); end
  endtask

  task automatic test_next_chain();
    apply_reset();
    press(1, 0, 0);
    press(0, 1, 0);
    cyc(1);
    checks++; if (mode !== 3'd3) begin errors++; $display("FAIL next_mins_mode got=%0d want=3", mode); end
    cyc(4);
    checks++; if (blank !== 4'b0011) begin errors++; $display("FAIL next_mins_blank got=%b want=0011", blank); end
    press(0, 1, 0);
    cyc(1);
    checks++; if (mode !== 3'd4) begin errors++; $display("FAIL next_day_mode got=%0d want=4", mode); end
    checks++; if ({dig3, dig2, dig1, dig0} !== DATE_V) begin errors++; $display("FAIL next_day_dig got=%h want=%h", {dig3, dig2, dig1, dig0}, DATE_V); end
    cyc(4);
    checks++; if (blank !== 4'b1100) begin errors++; $display("FAIL next_day_blank got=%b want=1100", blank); end
    press(0, 1, 0);
    cyc(1);
    checks++; if (mode !== 3'd5) begin errors++; $display("FAIL next_mon_mode got=%0d want=5", mode); end
    checks++; if ({dig3, dig2, dig1, dig0} !== DATE_V) begin errors++; $display("FAIL next_mon_dig got=%h want=%h", {dig3, dig2, dig1, dig0}, DATE_V); end
    press(0, 1, 0);
    cyc(1);
    checks++; if ({mode, blank} !== 7'b000_0000) begin errors++; $display("FAIL next_exit got=%b want=0000000", {mode, blank}); end
    checks++; if ({dig3, dig2, dig1, dig0} !== TIME_V) begin errors++; $display("FAIL next_exit_dig got=%h want=%h", {dig3, dig2, dig1, dig0}, TIME_V); end
  endtask

  task automatic test_priority();
    apply_reset();
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    cyc(1);
    checks++; if (mode !== 3'd4) begin errors++; $display("FAIL prio_day_mode got=%0d want=4", mode); end
    press(1, 0, 1);
    checks++; if ({inc_hrs, inc_mins, inc_day, inc_mon} !== 4'b0000) begin errors++; $display("FAIL prio_mode_inc got=%b want=0000", {inc_hrs, inc_mins, inc_day, inc_mon}); end
    cyc(1);
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL prio_abort_mode got=%0d want=0", mode); end
    press(0, 0, 1);
    checks++; if ({inc_hrs, inc_mins, inc_day, inc_mon} !== 4'b0000) begin errors++; $display("FAIL show_inc_ignored got=%b want=0000", {inc_hrs, inc_mins, inc_day, inc_mon}); end
    press(1, 0, 0);
    press(0, 1, 1);
    checks++; if (inc_hrs !== 1'b0) begin errors++; $display("FAIL prio_next_inc got=%b want=0", inc_hrs); end
    cyc(1);
    checks++; if (mode !== 3'd3) begin errors++; $display("FAIL prio_next_mode got=%0d want=3", mode); end
  endtask

  task automatic test_idle();
    apply_reset();
    press(1, 0, 0);
    press(0, 1, 0);
    cyc(48);
    checks++; if (mode !== 3'd3) begin errors++; $display("FAIL idle_before got=%0d want=3", mode); end
    cyc(1);
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL idle_exit got=%0d want=0", mode); end
    apply_reset();
    press(1, 0, 0);
    press(0, 1, 0);
    cyc(38);
    press(0, 1, 0);
    cyc(10);
    checks++; if (mode !== 3'd4) begin errors++; $display("FAIL idle_restart got=%0d want=4", mode); end
    cyc(39);
    checks++; if (mode !== 3'd4) begin errors++; $display("FAIL idle2_before got=%0d want=4", mode); end
    cyc(1);
    checks++; if (mode !== 3'd0) begin errors++; $display("FAIL idle2_exit got=%0d want=0", mode); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_inc_blink();
    test_next_chain();
    test_priority();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
